// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target: controller states,
// default target address, register pointer width and an address helper.
package i2c_pkg;

    localparam logic [6:0] DEFAULT_ADDRESS = 7'h50;
    localparam int         PTR_W           = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_WAIT_STOP
    } state_t;

    // General call (0) and the 10-bit address prefix 11110xx are never ours.
    function automatic logic addr_ackable(input logic [6:0] addr);
        return (addr != 7'h00) && (addr[6:2] != 5'b11110);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into clk, keeps one history flop per line and
// derives SCL edge pulses plus START/STOP pulses from the synchronized pair.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    // Fewer than two stages is not a synchronizer; clamp to the safe minimum.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] scl_sync_reg;
    logic [STAGES-1:0] sda_sync_reg;
    logic [STAGES-1:0] scl_sync_next;
    logic [STAGES-1:0] sda_sync_next;
    logic              scl_hist_reg;
    logic              sda_hist_reg;
    logic              scl_s;
    logic              sda_s;

    // Stage 0 takes the pad, every later stage takes its predecessor.
    assign scl_sync_next[0] = scl_i;
    assign sda_sync_next[0] = sda_i;

    genvar gi;
    generate
        for (gi = 1; gi < STAGES; gi++) begin : g_chain
            assign scl_sync_next[gi] = scl_sync_reg[gi-1];
            assign sda_sync_next[gi] = sda_sync_reg[gi-1];
        end
    endgenerate

    assign scl_s = scl_sync_reg[STAGES-1];
    assign sda_s = sda_sync_reg[STAGES-1];

    // Synchronizer chain and history flops; an idle bus reads as both lines high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_hist_reg <= 1'b1;
            sda_hist_reg <= 1'b1;
        end else begin
            scl_sync_reg <= scl_sync_next;
            sda_sync_reg <= sda_sync_next;
            scl_hist_reg <= scl_s;
            sda_hist_reg <= sda_s;
        end
    end

    // SDA may only move under a high SCL when it is a START or a STOP.
    assign sda       = sda_s;
    assign scl_rise  = scl_s & ~scl_hist_reg;
    assign scl_fall  = ~scl_s & scl_hist_reg;
    assign start_det = scl_s & scl_hist_reg & sda_hist_reg & ~sda_s;
    assign stop_det  = scl_s & scl_hist_reg & ~sda_hist_reg & sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target exposing a 16-entry register space: the first written byte
// sets the pointer, following bytes are written/read with auto-increment.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDRESS     = DEFAULT_ADDRESS,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    output logic [PTR_W-1:0] bus_addr,
    output logic [7:0]       bus_wdata,
    output logic             bus_wr,
    output logic             bus_rd,
    input  logic [7:0]       bus_rdata,
    output logic             busy
);

    localparam logic       ACK_ENABLED = addr_ackable(ADDRESS);
    localparam logic [3:0] BIT_LAST    = 4'd7;
    localparam logic [3:0] BYTE_DONE   = 4'd8;

    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    state_t             state_reg,     state_next;
    logic [3:0]         bit_cnt_reg,   bit_cnt_next;
    logic [7:0]         shift_reg,     shift_next;
    logic [PTR_W-1:0]   ptr_reg,       ptr_next;
    logic               rw_reg,        rw_next;
    logic               sda_oe_reg,    sda_oe_next;
    logic               bus_wr_reg,    bus_wr_next;
    logic               bus_rd_reg,    bus_rd_next;
    logic [PTR_W-1:0]   bus_addr_reg,  bus_addr_next;
    logic [7:0]         bus_wdata_reg, bus_wdata_next;
    logic               busy_reg,      busy_next;

    logic [7:0]         byte_in;
    logic               addr_match;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    // Byte as it will look once the bit on SDA right now is shifted in.
    assign byte_in    = {shift_reg[6:0], sda};
    assign addr_match = ACK_ENABLED && (shift_reg[7:1] == ADDRESS);

    // State and datapath registers; reset releases SDA without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            ptr_reg       <= '0;
            rw_reg        <= 1'b0;
            sda_oe_reg    <= 1'b0;
            bus_wr_reg    <= 1'b0;
            bus_rd_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            ptr_reg       <= ptr_next;
            rw_reg        <= rw_next;
            sda_oe_reg    <= sda_oe_next;
            bus_wr_reg    <= bus_wr_next;
            bus_rd_reg    <= bus_rd_next;
            bus_addr_reg  <= bus_addr_next;
            bus_wdata_reg <= bus_wdata_next;
            busy_reg      <= busy_next;
        end
    end

    // Protocol sequencing: bits are taken on SCL rise, SDA drive moves on SCL fall.
    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        ptr_next       = ptr_reg;
        rw_next        = rw_reg;
        sda_oe_next    = sda_oe_reg;
        bus_wr_next    = 1'b0;
        bus_rd_next    = 1'b0;
        bus_addr_next  = bus_addr_reg;
        bus_wdata_next = bus_wdata_reg;
        busy_next      = busy_reg;

        // Read data arrives one clk after the request; it becomes the next byte out.
        if (bus_rd_reg) begin
            shift_next = bus_rdata;
        end

        if (start_det) begin
            state_next   = ST_ADDR;
            bit_cnt_next = '0;
            sda_oe_next  = 1'b0;
            busy_next    = 1'b0;
        end else if (stop_det) begin
            state_next  = ST_IDLE;
            sda_oe_next = 1'b0;
            busy_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_WAIT_STOP: begin
                    // Only START/STOP matter here.
                end

                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise && (bit_cnt_reg < BYTE_DONE)) begin
                        shift_next   = byte_in;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == BIT_LAST) begin
                            if (state_reg == ST_PTR) begin
                                ptr_next = byte_in[PTR_W-1:0];
                            end else if (state_reg == ST_WDATA) begin
                                bus_wr_next    = 1'b1;
                                bus_addr_next  = ptr_reg;
                                bus_wdata_next = byte_in;
                                ptr_next       = ptr_reg + PTR_W'(1);
                            end
                        end
                    end else if (scl_fall && (bit_cnt_reg == BYTE_DONE)) begin
                        bit_cnt_next = '0;
                        if (state_reg == ST_ADDR) begin
                            if (addr_match) begin
                                state_next  = ST_ADDR_ACK;
                                sda_oe_next = 1'b1;
                                busy_next   = 1'b1;
                                rw_next     = shift_reg[0];
                            end else begin
                                state_next  = ST_WAIT_STOP;
                                sda_oe_next = 1'b0;
                            end
                        end else if (state_reg == ST_PTR) begin
                            state_next  = ST_PTR_ACK;
                            sda_oe_next = 1'b1;
                        end else begin
                            state_next  = ST_WDATA_ACK;
                            sda_oe_next = 1'b1;
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_rise && rw_reg) begin
                        // Fetch the first read byte while our ACK is on the bus.
                        bus_rd_next   = 1'b1;
                        bus_addr_next = ptr_reg;
                        ptr_next      = ptr_reg + PTR_W'(1);
                    end else if (scl_fall) begin
                        bit_cnt_next = '0;
                        if (rw_reg) begin
                            state_next  = ST_RDATA;
                            sda_oe_next = ~shift_reg[7];
                        end else begin
                            state_next  = ST_PTR;
                            sda_oe_next = 1'b0;
                        end
                    end
                end

                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        state_next   = ST_WDATA;
                        bit_cnt_next = '0;
                        sda_oe_next  = 1'b0;
                    end
                end

                ST_RDATA: begin
                    if (scl_rise && (bit_cnt_reg < BYTE_DONE)) begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_reg == BYTE_DONE) begin
                            // Release SDA so the master can ACK/NACK.
                            state_next  = ST_RDATA_ACK;
                            sda_oe_next = 1'b0;
                        end else begin
                            shift_next  = {shift_reg[6:0], 1'b0};
                            sda_oe_next = ~shift_reg[6];
                        end
                    end
                end

                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda) begin
                            // NACK ends the read; no further fetch.
                            state_next = ST_WAIT_STOP;
                        end else begin
                            bus_rd_next   = 1'b1;
                            bus_addr_next = ptr_reg;
                            ptr_next      = ptr_reg + PTR_W'(1);
                        end
                    end else if (scl_fall) begin
                        state_next   = ST_RDATA;
                        bit_cnt_next = '0;
                        sda_oe_next  = ~shift_reg[7];
                    end
                end

                default: begin
                    state_next  = ST_IDLE;
                    sda_oe_next = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe    = sda_oe_reg;
    assign bus_wr    = bus_wr_reg;
    assign bus_rd    = bus_rd_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_wdata = bus_wdata_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master, a 16-byte register device on
// the bus side, and a register-file model of what the target should do.
`timescale 1ns/1ps
module tb_i2c_target;

    localparam int Q = 8;   // clk cycles per quarter SCL period (SCL = clk/32)

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m;
    logic       sda_m;
    logic       sda_oe;
    logic [3:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_wr;
    logic       bus_rd;
    logic [7:0] bus_rdata;
    logic       busy;
    wire        sda_line = sda_m & ~sda_oe;

    int checks   = 0;
    int failures = 0;

    // bus-side device and strobe bookkeeping
    logic [7:0] dev_mem   [16];
    logic [7:0] model_mem [16];
    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    logic [7:0] rd_addr_q[$];
    int         viol       = 0;
    int         oe_cycles  = 0;
    int         busy_cycles = 0;
    logic       prev_wr    = 1'b0;
    logic       prev_rd    = 1'b0;

    always #5 clk = ~clk;

    i2c_target #(
        .ADDRESS     (7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (scl_m),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wr    (bus_wr),
        .bus_rd    (bus_rd),
        .bus_rdata (bus_rdata),
        .busy      (busy)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called once per clk at the falling edge: bus device + strobe rules.
    task automatic sample();
        if (bus_wr && bus_rd) viol++;
        if (bus_wr && prev_wr) viol++;
        if (bus_rd && prev_rd) viol++;
        prev_wr = bus_wr;
        prev_rd = bus_rd;
        if (bus_wr) begin
            wr_addr_q.push_back({4'h0, bus_addr});
            wr_data_q.push_back(bus_wdata);
            dev_mem[bus_addr] = bus_wdata;
        end
        if (bus_rd) begin
            rd_addr_q.push_back({4'h0, bus_addr});
            bus_rdata = dev_mem[bus_addr];
        end
        if (sda_oe) oe_cycles++;
        if (busy) busy_cycles++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            sample();
        end
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        b = sda_line; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic acked);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(a);
        acked = ~a;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~ack);
    endtask

    initial begin
        logic       a;
        logic [7:0] d;
        logic [3:0] p;
        int         n;
        int         oe0;
        int         busy0;

        reset = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        bus_rdata = 8'h00;
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            dev_mem[i]   = d;
            model_mem[i] = d;
        end
        tick(4);
        check("rst_sda_oe",    sda_oe,    0);
        check("rst_bus_wr",    bus_wr,    0);
        check("rst_bus_rd",    bus_rd,    0);
        check("rst_busy",      busy,      0);
        check("rst_bus_addr",  bus_addr,  0);
        check("rst_bus_wdata", bus_wdata, 0);
        reset = 1'b0;
        tick(4);

        // Two-byte write starting at pointer 3
        clear_logs();
        i2c_start();
        send_byte(8'hA0, a); check("w1_ack_addr", a, 1);
        send_byte(8'h03, a); check("w1_ack_ptr",  a, 1);
        send_byte(8'h11, a); check("w1_ack_d0",   a, 1);
        send_byte(8'h22, a); check("w1_ack_d1",   a, 1);
        check("w1_busy_before_stop", busy, 1);
        i2c_stop();
        check("w1_busy_after_stop", busy, 0);
        model_mem[3] = 8'h11;
        model_mem[4] = 8'h22;
        check("w1_wr_count", wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            check("w1_addr0", wr_addr_q[0], 8'h03);
            check("w1_data0", wr_data_q[0], 8'h11);
            check("w1_addr1", wr_addr_q[1], 8'h04);
            check("w1_data1", wr_data_q[1], 8'h22);
        end

        // Pointer wraps from 0xF to 0x0
        clear_logs();
        i2c_start();
        send_byte(8'hA0, a);
        send_byte(8'h0F, a);
        send_byte(8'hAA, a); check("w2_ack_d0", a, 1);
        send_byte(8'hBB, a); check("w2_ack_d1", a, 1);
        i2c_stop();
        model_mem[15] = 8'hAA;
        model_mem[0]  = 8'hBB;
        check("w2_wr_count", wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            check("w2_addr0", wr_addr_q[0], 8'h0F);
            check("w2_data0", wr_data_q[0], 8'hAA);
            check("w2_addr1", wr_addr_q[1], 8'h00);
            check("w2_data1", wr_data_q[1], 8'hBB);
        end

        // Set pointer 5, repeated START, read two bytes (ACK then NACK)
        dev_mem[5] = 8'h5A; model_mem[5] = 8'h5A;
        dev_mem[6] = 8'hC3; model_mem[6] = 8'hC3;
        clear_logs();
        i2c_start();
        send_byte(8'hA0, a);
        send_byte(8'h05, a); check("r1_ack_ptr", a, 1);
        i2c_start();
        send_byte(8'hA1, a); check("r1_ack_addr", a, 1);
        recv_byte(1'b1, d);  check("r1_data0", d, 8'h5A);
        recv_byte(1'b0, d);  check("r1_data1", d, 8'hC3);
        i2c_stop();
        tick(4 * Q);
        check("r1_rd_count", rd_addr_q.size(), 2);
        check("r1_wr_count", wr_addr_q.size(), 0);
        if (rd_addr_q.size() == 2) begin
            check("r1_rd_addr0", rd_addr_q[0], 8'h05);
            check("r1_rd_addr1", rd_addr_q[1], 8'h06);
        end

        // Foreign address 7'h51: no ACK, no strobes, never busy
        clear_logs();
        oe0   = oe_cycles;
        busy0 = busy_cycles;
        i2c_start();
        send_byte(8'hA2, a); check("nm_ack_addr", a, 0);
        send_byte(8'h00, a); check("nm_ack_data", a, 0);
        check("nm_busy_before_stop", busy, 0);
        i2c_stop();
        check("nm_oe_cycles",   oe_cycles - oe0,     0);
        check("nm_busy_cycles", busy_cycles - busy0, 0);
        check("nm_strobes", wr_addr_q.size() + rd_addr_q.size(), 0);

        // Reset after 4 address bits, then a complete write
        clear_logs();
        i2c_start();
        for (int i = 7; i >= 4; i--) send_bit(p_bit(8'hA0, i));
        reset = 1'b1;
        #1;
        check("mr_sda_oe", sda_oe, 0);
        check("mr_busy",   busy,   0);
        tick(3);
        reset = 1'b0;
        tick(Q);
        i2c_start();
        send_byte(8'hA0, a); check("mr_ack_addr", a, 1);
        send_byte(8'h01, a); check("mr_ack_ptr",  a, 1);
        send_byte(8'h7E, a); check("mr_ack_data", a, 1);
        i2c_stop();
        model_mem[1] = 8'h7E;
        check("mr_wr_count", wr_addr_q.size(), 1);
        if (wr_addr_q.size() == 1) begin
            check("mr_addr", wr_addr_q[0], 8'h01);
            check("mr_data", wr_data_q[0], 8'h7E);
        end

        // Reset while the target is driving its ACK, then traffic without START
        clear_logs();
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(p_bit(8'hA0, i));
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(2);
        check("ar_sda_oe_ack", sda_oe, 1);
        reset = 1'b1;
        #1;
        check("ar_sda_oe_reset", sda_oe, 0);
        tick(3);
        reset = 1'b0;
        tick(Q);
        scl_m = 1'b0; tick(Q);
        send_byte(8'hA0, a); check("ar_ignored_ack", a, 0);
        i2c_stop();
        check("ar_strobes", wr_addr_q.size() + rd_addr_q.size(), 0);

        // Randomized write bursts and read-backs against the register-file model
        for (int k = 0; k < 4; k++) begin
            clear_logs();
            p = 4'($urandom_range(0, 15));
            n = $urandom_range(1, 4);
            i2c_start();
            send_byte(8'hA0, a);
            send_byte({4'($urandom), p}, a);
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom);
                send_byte(d, a);
                check($sformatf("rw%0d_ack%0d", k, i), a, 1);
                model_mem[4'(p + i)] = d;
            end
            i2c_stop();
            check($sformatf("rw%0d_wr_count", k), wr_addr_q.size(), n);
            for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
                check($sformatf("rw%0d_addr%0d", k, i), wr_addr_q[i], {4'h0, 4'(p + i)});
                check($sformatf("rw%0d_data%0d", k, i), wr_data_q[i], model_mem[4'(p + i)]);
            end

            clear_logs();
            p = 4'($urandom_range(0, 15));
            n = $urandom_range(1, 4);
            i2c_start();
            send_byte(8'hA0, a);
            send_byte({4'($urandom), p}, a);
            i2c_start();
            send_byte(8'hA1, a);
            for (int i = 0; i < n; i++) begin
                recv_byte(i < n - 1, d);
                check($sformatf("rr%0d_data%0d", k, i), d, model_mem[4'(p + i)]);
            end
            i2c_stop();
            check($sformatf("rr%0d_rd_count", k), rd_addr_q.size(), n);
            for (int i = 0; i < n && i < rd_addr_q.size(); i++) begin
                check($sformatf("rr%0d_addr%0d", k, i), rd_addr_q[i], {4'h0, 4'(p + i)});
            end
        end

        check("strobe_rules", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic p_bit(input logic [7:0] v, input int i);
        return v[i];
    endfunction

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter ADDRESS, default 7'h50, 7-bit target address matched after START.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on scl_i/sda_i (minimum 2).
REQ-003 clk  input  1  single block clock; clk SHALL be at least 16x the SCL frequency.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 scl_i  input  1  SCL line level; input only, no clock stretching.
REQ-006 sda_i  input  1  SDA line level.
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain enable); 0 = released.
REQ-008 bus_addr  output  4  register pointer presented with bus_wr/bus_rd.
REQ-009 bus_wdata  output  8  write byte, valid while bus_wr=1.
REQ-010 bus_wr  output  1  one-clk write strobe.
REQ-011 bus_rd  output  1  one-clk read request.
REQ-012 bus_rdata  input  8  read byte, sampled exactly one clk after bus_rd.
REQ-013 busy  output  1  1 from own-address ACK until the next STOP or START.

Function
REQ-014 scl_i/sda_i pass through SYNC_STAGES flops plus one history flop; all edges and START/STOP are detected on the synchronized signals only.
REQ-015 START = synchronized SDA falling while SCL high; STOP = SDA rising while SCL high.
REQ-016 SDA is sampled on the SCL rising edge; sda_oe changes only in the clk after a detected SCL falling edge.
REQ-017 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-018 IDLE -> ADDR on START; ADDR shifts 8 bits, MSB first (7 address bits, then R/W).
REQ-019 Address match -> ADDR_ACK (sda_oe=1 for the 9th SCL period), then PTR if W, RDATA if R; mismatch -> WAIT_STOP with sda_oe=0.
REQ-020 PTR: the 8th bit loads pointer <= byte[3:0]; upper 4 bits ignored; ACK, then WDATA.
REQ-021 WDATA: one clk after the 8th bit is sampled, bus_wr=1 with bus_addr=pointer, bus_wdata=byte; ACK; pointer <= pointer+1 mod 16.
REQ-022 Read: one clk after the SCL rising edge of the 9th bit (own address ACK, or master ACK in RDATA_ACK), bus_rd=1 with bus_addr=pointer; bus_rdata is loaded into the shift register on the next clk; pointer increments mod 16.
REQ-023 RDATA drives the inverted data bit on sda_oe, MSB first, changing after each SCL fall; sda_oe=0 during the master ACK slot.
REQ-024 RDATA_ACK: master ACK (SDA low) -> RDATA with the next byte; master NACK -> WAIT_STOP, no further bus_rd.
REQ-025 A START in any state -> ADDR (repeated start), sda_oe=0, pointer retained.
REQ-026 A STOP in any state -> IDLE, sda_oe=0, busy=0.
REQ-027 At most one of bus_wr/bus_rd is high in any clk; each is high for exactly one clk per byte.
REQ-028 General call (address 0) and 10-bit addressing are not acknowledged.

Reset
REQ-029 Reset forces state=IDLE, sda_oe=0, bus_wr=0, bus_rd=0, busy=0, bus_addr=0, bus_wdata=0, pointer=0, shift register=0, synchronizer flops=1.
REQ-030 Reset mid-transfer releases SDA in the same cycle (async); after reset the block ignores traffic until the next START.

Structure
REQ-031 Shared package i2c_pkg holds the state enumeration, the default target address constant and the pointer width (4).
REQ-032 Sub-module i2c_line_sync (synchronizer, history flop, SCL rise/fall, START/STOP pulses) is instantiated once.

Verification
REQ-033 Write 0xA0, 0x03, 0x11, 0x22, STOP -> four ACKs; bus_wr at addr 3/0x11 then addr 4/0x22; busy falls at STOP.
REQ-034 Write 0xA0, 0x0F, 0xAA, 0xBB -> bus_wr at addr 0xF/0xAA then addr 0x0/0xBB (wrap).
REQ-035 Write 0xA0, 0x05, repeated START, 0xA1, read 2 bytes (ACK, NACK) with bus_rdata = 0x5A then 0xC3 -> bus_rd at addr 5 and 6; SDA carries 0x5A, 0xC3; no third bus_rd.
REQ-036 Address 0xA2 (7'h51) write 0x00 -> SDA never pulled low, no bus strobes, busy stays 0 until STOP.
REQ-037 Reset asserted after 4 bits of 0xA0, then a full write 0xA0, 0x01, 0x7E -> sda_oe=0 immediately; bus_wr at addr 1/0x7E only.
